// File: rtl/uart_rx_os16_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os16_if
// Bundles the serial line and the byte-side outputs of the UART receiver.
//   rx            : asynchronous serial line into the receiver (idle high)
//   data_out      : last correctly framed byte
//   data_ready    : one-cycle strobe, data_out just updated
//   framing_error : one-cycle strobe, stop bit sampled low
//   busy          : receiver is somewhere other than IDLE
// modport master : the receiver side (consumes rx, produces the byte outputs)
// modport slave  : the line driver / byte consumer side
// -----------------------------------------------------------------------------
interface uart_rx_os16_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       busy;

    modport master (
        input  rx,
        output data_out,
        output data_ready,
        output framing_error,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_ready,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// The bit clock comes from a fractional accumulator, so a non-integer ratio
// such as 27 MHz / (115200*16) produces no cumulative rate error.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : uart_rx_os16_if.master
//            rx (in), data_out[7:0], data_ready, framing_error, busy (out)
//
// Timing within one bit: tick_cnt_r counts 0..15. Samples are taken on the
// ticks where tick_cnt_r is 7 and 8, and the bit is decided on the tick where
// tick_cnt_r is 9 (using the live synchronized value as the third sample).
// The tick where tick_cnt_r is 15 is the bit boundary.
// -----------------------------------------------------------------------------
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ   = 27000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rx_os16_if.master    bus
);

    // Receiver states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // Accumulator step and modulus for the fractional tick generator
    localparam logic [31:0] ACC_INC = 32'(BAUD_RATE * OVERSAMPLE);
    localparam logic [31:0] ACC_MOD = 32'(CLK_FREQ);

    localparam logic [3:0] TICK_SAMPLE_A = 4'd7;
    localparam logic [3:0] TICK_SAMPLE_B = 4'd8;
    localparam logic [3:0] TICK_DECIDE   = 4'd9;
    localparam logic [3:0] TICK_LAST     = 4'd15;

    // 3-input majority vote used to decide each bit
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // Synchronizer
    logic        rx_meta_r;
    logic        rxs_r;

    // Tick generator
    logic [31:0] acc_r;
    logic [31:0] acc_sum_s;
    logic        tick_s;
    logic [3:0]  tick_cnt_r;

    // Sample and decision helpers
    logic        samp_a_r;
    logic        samp_b_r;
    logic        maj_s;
    logic        at_decide_s;
    logic        at_wrap_s;

    // Frame state
    logic [2:0]  state_r;
    logic [2:0]  state_n_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_n_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_n_s;
    logic        clr_timing_s;

    // Registered outputs
    logic [7:0]  data_out_r;
    logic [7:0]  data_out_n_s;
    logic        data_ready_r;
    logic        data_ready_n_s;
    logic        framing_error_r;
    logic        framing_error_n_s;
    logic        busy_r;

    assign bus.data_out      = data_out_r;
    assign bus.data_ready    = data_ready_r;
    assign bus.framing_error = framing_error_r;
    assign bus.busy          = busy_r;

    // Two-flop synchronizer on the asynchronous serial line (resets to idle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rxs_r     <= rx_meta_r;
        end
    end

    // Tick strobe and bit-position decode
    always_comb begin
        acc_sum_s   = acc_r + ACC_INC;
        tick_s      = (acc_sum_s >= ACC_MOD);
        maj_s       = maj3(samp_a_r, samp_b_r, rxs_r);
        at_decide_s = tick_s && (tick_cnt_r == TICK_DECIDE);
        at_wrap_s   = tick_s && (tick_cnt_r == TICK_LAST);
    end

    // Fractional accumulator and tick counter; both restart on the start edge
    // so that the 16 ticks of each bit line up with the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= 32'd0;
            tick_cnt_r <= 4'd0;
        end else if (clr_timing_s) begin
            acc_r      <= 32'd0;
            tick_cnt_r <= 4'd0;
        end else if (tick_s) begin
            acc_r      <= acc_sum_s - ACC_MOD;
            tick_cnt_r <= tick_cnt_r + 4'd1;
        end else begin
            acc_r      <= acc_sum_s;
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Capture the first two of the three majority samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else if (tick_s && (tick_cnt_r == TICK_SAMPLE_A)) begin
            samp_a_r <= rxs_r;
            samp_b_r <= samp_b_r;
        end else if (tick_s && (tick_cnt_r == TICK_SAMPLE_B)) begin
            samp_a_r <= samp_a_r;
            samp_b_r <= rxs_r;
        end else begin
            samp_a_r <= samp_a_r;
            samp_b_r <= samp_b_r;
        end
    end

    // Frame state machine: next-state and next-output decode
    always_comb begin
        state_n_s         = state_r;
        bit_idx_n_s       = bit_idx_r;
        shift_n_s         = shift_r;
        data_out_n_s      = data_out_r;
        data_ready_n_s    = 1'b0;
        framing_error_n_s = 1'b0;
        clr_timing_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_n_s    = ST_START;
                    clr_timing_s = 1'b1;
                end else begin
                    state_n_s    = ST_IDLE;
                end
            end

            ST_START: begin
                // A start bit that votes high at mid-bit was only a glitch
                if (at_decide_s && maj_s) begin
                    state_n_s = ST_IDLE;
                end else if (at_wrap_s) begin
                    state_n_s   = ST_DATA;
                    bit_idx_n_s = 3'd0;
                end else begin
                    state_n_s = ST_START;
                end
            end

            ST_DATA: begin
                if (at_decide_s) begin
                    // LSB arrives first, so shift in from the top
                    shift_n_s = {maj_s, shift_r[7:1]};
                end else if (at_wrap_s) begin
                    if (bit_idx_r == 3'd7) begin
                        state_n_s = ST_STOP;
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_n_s = ST_DATA;
                end
            end

            ST_STOP: begin
                // Leave at mid-stop-bit so a start bit immediately after the
                // stop bit is still caught by IDLE
                if (at_decide_s) begin
                    if (maj_s) begin
                        data_out_n_s   = shift_r;
                        data_ready_n_s = 1'b1;
                        state_n_s      = ST_IDLE;
                    end else begin
                        framing_error_n_s = 1'b1;
                        state_n_s         = ST_WAIT_IDLE;
                    end
                end else begin
                    state_n_s = ST_STOP;
                end
            end

            ST_WAIT_IDLE: begin
                // Break or stuck-low line: do not re-arm until it goes high
                if (rxs_r) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WAIT_IDLE;
                end
            end

            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            bit_idx_r       <= 3'd0;
            shift_r         <= 8'h00;
            data_out_r      <= 8'h00;
            data_ready_r    <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            state_r         <= state_n_s;
            bit_idx_r       <= bit_idx_n_s;
            shift_r         <= shift_n_s;
            data_out_r      <= data_out_n_s;
            data_ready_r    <= data_ready_n_s;
            framing_error_r <= framing_error_n_s;
            busy_r          <= (state_n_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os16
// Drives serial frames at nominal and skewed baud rates, pushes the expected
// receiver response for each frame into a queue, and lets an independent
// monitor pop and compare on every data_ready / framing_error strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_os16;

    localparam real CLK_P = 1.0e9 / 27000000.0;
    localparam real BIT_P = 1.0e9 / 115200.0;

    typedef struct {
        bit         fe;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_os16_if bus_if();

    uart_rx_os16 #(
        .CLK_FREQ   (27000000),
        .BAUD_RATE  (115200),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #(CLK_P / 2.0) clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one 8N1 frame; the expected outcome is queued before the first bit
    task automatic send_frame(input logic [7:0] d, input real bp, input logic stop_val,
                              input int glitch_bit, input bit expect_it);
        exp_t e;
        logic v;
        if (expect_it) begin
            e.fe = !stop_val;
            e.d  = d;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop_val;
            else             v = d[i-1];
            bus_if.rx = v;
            if (glitch_bit >= 0 && i == glitch_bit + 1) begin
                // one-clock flip near the middle sample of this bit
                #(bp * 9.0 / 16.0 + 2.5 * CLK_P);
                bus_if.rx = ~v;
                #(CLK_P);
                bus_if.rx = v;
                #(bp - bp * 9.0 / 16.0 - 3.5 * CLK_P);
            end else begin
                #(bp);
            end
        end
    endtask

    // Wait (bounded) until every queued expectation has been consumed
    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: pops one expectation per strobe and compares
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                last_good = 8'h00;
            end else if (bus_if.data_ready || bus_if.framing_error) begin
                chk("strobe_exclusive", int'(bus_if.data_ready && bus_if.framing_error), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got dr=%0b fe=%0b data=%0h expected none at %0t",
                             bus_if.data_ready, bus_if.framing_error, bus_if.data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.fe) begin
                        chk("fe_kind", int'(bus_if.framing_error), 1);
                        chk("fe_data_hold", int'(bus_if.data_out), int'(last_good));
                    end else begin
                        chk("dr_kind", int'(bus_if.data_ready), 1);
                        chk("rx_byte", int'(bus_if.data_out), int'(e.d));
                        last_good = e.d;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] rb;
        int         gap;
        real        bp;

        rst_n     = 1'b0;
        bus_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data_out", int'(bus_if.data_out), 0);
        chk("reset_data_ready", int'(bus_if.data_ready), 0);
        chk("reset_framing_error", int'(bus_if.framing_error), 0);
        chk("reset_busy", int'(bus_if.busy), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // single byte with an extra idle bit
        send_frame(8'h55, BIT_P, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("b55");
        @(negedge clk);
        chk("idle_busy_after_55", int'(bus_if.busy), 0);

        // back-to-back frames, no gap
        send_frame(8'h00, BIT_P, 1'b1, -1, 1'b1);
        send_frame(8'hFF, BIT_P, 1'b1, -1, 1'b1);
        send_frame(8'hA5, BIT_P, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("b2b");

        // short low glitch on an idle line
        bus_if.rx = 1'b0;
        #(BIT_P * 2.0 / 16.0);
        @(negedge clk);
        chk("glitch_busy_seen", int'(bus_if.busy), 1);
        #(BIT_P * 2.0 / 16.0);
        bus_if.rx = 1'b1;
        #(BIT_P);
        @(negedge clk);
        chk("glitch_busy_clear", int'(bus_if.busy), 0);

        // framing error followed by a held-low line, then recovery
        send_frame(8'h3C, BIT_P, 1'b0, -1, 1'b1);
        #(2.0 * BIT_P);
        @(negedge clk);
        chk("fe_busy_while_low", int'(bus_if.busy), 1);
        wait_drain("fe");
        bus_if.rx = 1'b1;
        #(BIT_P);
        @(negedge clk);
        chk("fe_busy_after_high", int'(bus_if.busy), 0);
        send_frame(8'h12, BIT_P, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("after_fe");

        // +/-4% sender rate
        send_frame(8'hC3, BIT_P / 1.04, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("fast");
        send_frame(8'hC3, BIT_P / 0.96, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("slow");

        // one-clock glitch in data bit 3
        send_frame(8'h96, BIT_P, 1'b1, 3, 1'b1);
        #(BIT_P);
        wait_drain("vote");

        // random bytes, rates and gaps
        for (int k = 0; k < 6; k++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            bp  = BIT_P * (0.97 + 0.01 * real'($urandom_range(0, 6)));
            send_frame(rb, bp, 1'b1, -1, 1'b1);
            #(bp * real'(gap));
        end
        #(BIT_P);
        wait_drain("random");

        // reset in the middle of data bit 4
        bus_if.rx = 1'b0;
        #(BIT_P);
        for (int i = 0; i < 4; i++) begin
            bus_if.rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            #(BIT_P);
        end
        bus_if.rx = 1'b1;
        #(BIT_P / 2.0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_data_out", int'(bus_if.data_out), 0);
        chk("midreset_busy", int'(bus_if.busy), 0);
        rst_n = 1'b1;
        #(BIT_P);
        @(negedge clk);
        chk("post_reset_data_out", int'(bus_if.data_out), 0);
        chk("post_reset_busy", int'(bus_if.busy), 0);
        send_frame(8'h81, BIT_P, 1'b1, -1, 1'b1);
        #(BIT_P);
        wait_drain("after_reset");
        @(negedge clk);
        chk("final_data_out", int'(bus_if.data_out), 8'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
